// File: rtl/banzai_ctrl_pkg.sv
// Shared types and sizing helpers for the inference sequencer and its timer.
package banzai_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE, PROG, PACK, CLR, LOAD, SETTLE, ACC, DONE
    } seq_state_t;

    typedef struct packed {
        logic busy;
        logic prog;
        logic read_mem;
        logic adr_0;
        logic inference_en;
        logic read_out;
        logic stoch_log;
        logic prog_ack;
        logic done;
    } ctrl_t;

    function automatic int row_width(input int n_obs);
        return (n_obs > 1) ? $clog2(n_obs) : 1;
    endfunction

    function automatic int acc_width(input int m, input int n_obs);
        return m + $clog2(n_obs);
    endfunction

    // Column control lines as seen while the FSM sits in state s.
    function automatic ctrl_t ctrl_decode(input seq_state_t s, input logic mode);
        ctrl_t c;
        c = '0;
        c.busy = (s != IDLE);
        case (s)
            PROG:   begin c.prog = 1'b1; c.stoch_log = 1'b1; end
            PACK:   c.prog_ack = 1'b1;
            CLR:    begin c.read_mem = 1'b1; c.stoch_log = 1'b1; end
            LOAD: begin
                c.stoch_log = 1'b1;
                if (mode) begin
                    c.inference_en = 1'b1;
                end else begin
                    c.read_mem = 1'b1;
                    c.adr_0    = 1'b1;
                end
            end
            SETTLE: c.read_out = 1'b1;
            ACC:    c.read_out = 1'b1;
            DONE:   c.done = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter with a zero flag; times the PROG hold and SETTLE wait.
module cycle_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/inference_sequencer.sv
// Sequences the column chain through N_OBS clear/load/settle/accumulate rows and
// arbitrates host programming passes onto the same column control lines.
module inference_sequencer
    import banzai_ctrl_pkg::*;
#(
    parameter int M         = 8,
    parameter int N_OBS     = 4,
    parameter int CHAIN_LAT = 2,
    parameter int PROG_CYC  = 3
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic                               stoch_mode,
    input  logic                               prog_req,
    output logic                               prog_ack,
    output logic                               busy,
    output logic [row_width(N_OBS)-1:0]        row_sel,
    output logic                               prog,
    output logic                               read_mem,
    output logic                               adr_0,
    output logic                               inference_en,
    output logic                               read_out,
    output logic                               stoch_log,
    input  logic [M-1:0]                       chain_in,
    output logic [acc_width(M, N_OBS)-1:0]     result,
    output logic                               done
);

    localparam int ROW_W = row_width(N_OBS);
    localparam int ACC_W = acc_width(M, N_OBS);
    localparam int TMR_W = $clog2((PROG_CYC > CHAIN_LAT) ? PROG_CYC : CHAIN_LAT) + 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N_OBS - 1);

    seq_state_t       state, nxt_state;
    logic             mode;
    logic [ACC_W-1:0] acc, acc_sum;
    logic             t_load, t_zero;
    logic [TMR_W-1:0] t_val;
    ctrl_t            ctrl_nxt;

    assign acc_sum  = acc + ACC_W'(chain_in);
    assign ctrl_nxt = ctrl_decode(nxt_state, mode);

    // Timer is reloaded on entry to each timed wait; it reaches zero in the last cycle.
    assign t_load = (state == LOAD) || (state == IDLE && nxt_state == PROG);
    assign t_val  = (state == LOAD) ? TMR_W'(CHAIN_LAT - 1) : TMR_W'(PROG_CYC - 1);

    cycle_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (t_load),
        .load_val (t_val),
        .zero     (t_zero)
    );

    always_comb begin
        nxt_state = state;
        case (state)
            IDLE:   if (prog_req) nxt_state = PROG;
                    else if (start) nxt_state = CLR;
            PROG:   if (t_zero) nxt_state = PACK;
            PACK:   nxt_state = IDLE;
            CLR:    nxt_state = LOAD;
            LOAD:   nxt_state = SETTLE;
            SETTLE: if (t_zero) nxt_state = ACC;
            ACC:    nxt_state = (row_sel == LAST_ROW) ? DONE : CLR;
            DONE:   nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            mode    <= 1'b0;
            acc     <= '0;
            row_sel <= '0;
            result  <= '0;
            {busy, prog, read_mem, adr_0, inference_en,
             read_out, stoch_log, prog_ack, done} <= '0;
        end else begin
            state <= nxt_state;
            {busy, prog, read_mem, adr_0, inference_en,
             read_out, stoch_log, prog_ack, done} <= ctrl_nxt;
            case (state)
                IDLE: if (!prog_req && start) begin
                    acc     <= '0;
                    row_sel <= '0;
                    mode    <= stoch_mode;
                end
                ACC: begin
                    acc <= acc_sum;
                    if (row_sel == LAST_ROW) result  <= acc_sum;
                    else                     row_sel <= row_sel + ROW_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inference_sequencer.sv
// Directed bench for inference_sequencer: runs, collisions, deferred prog, async reset.
module tb_inference_sequencer;

    localparam int M         = 8;
    localparam int N_OBS     = 4;
    localparam int CHAIN_LAT = 2;
    localparam int PROG_CYC  = 3;
    localparam int ROWLEN    = 3 + CHAIN_LAT;
    localparam int RUN_CYC   = N_OBS * ROWLEN;

    localparam logic [8:0] B_BUSY = 9'h100, B_PROG = 9'h080, B_RMEM = 9'h040,
                           B_ADR0 = 9'h020, B_INF  = 9'h010, B_ROUT = 9'h008,
                           B_SLOG = 9'h004, B_ACK  = 9'h002, B_DONE = 9'h001;

    logic       clk = 1'b0;
    logic       rst;
    logic       start = 1'b0, stoch_mode = 1'b0, prog_req = 1'b0;
    logic       prog_ack, busy, prog, read_mem, adr_0, inference_en, read_out, stoch_log, done;
    logic [1:0] row_sel;
    logic [7:0] chain_in = '0;
    logic [9:0] result;
    logic [8:0] ctrl_obs;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] last_result = '0;

    always #5 clk = ~clk;

    inference_sequencer #(
        .M(M), .N_OBS(N_OBS), .CHAIN_LAT(CHAIN_LAT), .PROG_CYC(PROG_CYC)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stoch_mode(stoch_mode),
        .prog_req(prog_req), .prog_ack(prog_ack), .busy(busy), .row_sel(row_sel),
        .prog(prog), .read_mem(read_mem), .adr_0(adr_0), .inference_en(inference_en),
        .read_out(read_out), .stoch_log(stoch_log), .chain_in(chain_in),
        .result(result), .done(done)
    );

    assign ctrl_obs = {busy, prog, read_mem, adr_0, inference_en, read_out, stoch_log, prog_ack, done};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] exp_run(input int ph, input logic mode);
        if (ph == 0) return B_BUSY | B_RMEM | B_SLOG;
        if (ph == 1) return B_BUSY | B_SLOG | (mode ? B_INF : (B_RMEM | B_ADR0));
        return B_BUSY | B_ROUT;
    endfunction

    // Called in the first PROG cycle; releases prog_req on seeing the ack.
    task automatic prog_pass(input string tag);
        for (int i = 0; i < PROG_CYC; i++) begin
            check($sformatf("%s_prog%0d", tag, i), 32'(ctrl_obs), 32'(B_BUSY | B_PROG | B_SLOG));
            @(negedge clk);
        end
        check({tag, "_ack"}, 32'(ctrl_obs), 32'(B_BUSY | B_ACK));
        prog_req = 1'b0;
        @(negedge clk);
        check({tag, "_idle"}, 32'(ctrl_obs), 32'h0);
    endtask

    task automatic run(input string tag, input logic mode, input logic [31:0] vals,
                       input int prog_at, input logic [31:0] exp_sum);
        stoch_mode = mode;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        stoch_mode = ~mode;
        for (int c = 1; c <= RUN_CYC; c++) begin
            int row, ph;
            row = (c - 1) / ROWLEN;
            ph  = (c - 1) % ROWLEN;
            chain_in = vals[row*8 +: 8];
            if (c == prog_at) prog_req = 1'b1;
            if (c == 1) check({tag, "_hold_result"}, 32'(result), last_result);
            check($sformatf("%s_ctrl_c%0d", tag, c), 32'(ctrl_obs), 32'(exp_run(ph, mode)));
            check($sformatf("%s_row_c%0d", tag, c), 32'(row_sel), 32'(row));
            @(negedge clk);
        end
        chain_in = '0;
        check({tag, "_done"}, 32'(ctrl_obs), 32'(B_BUSY | B_DONE));
        check({tag, "_result"}, 32'(result), exp_sum);
        @(negedge clk);
        check({tag, "_after"}, 32'(ctrl_obs), 32'h0);
        check({tag, "_result_held"}, 32'(result), exp_sum);
        last_result = exp_sum;
        if (prog_at != 0) begin
            @(negedge clk);
            prog_pass({tag, "_deferred"});
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_ctrl", 32'(ctrl_obs), 32'h0);
        check("reset_row", 32'(row_sel), 32'h0);
        check("reset_result", 32'(result), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ctrl", 32'(ctrl_obs), 32'h0);

        run("basic", 1'b0, {8'd40, 8'd30, 8'd20, 8'd10}, 0, 32'd100);
        run("max",   1'b0, {4{8'hFF}}, 0, 32'd1020);

        // start and prog_req together: prog wins, start is dropped
        stoch_mode = 1'b0;
        start      = 1'b1;
        prog_req   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        prog_pass("collide");
        repeat (2) begin
            @(negedge clk);
            check("collide_no_run", 32'(ctrl_obs), 32'h0);
        end
        check("collide_result", 32'(result), 32'd1020);

        run("stoch", 1'b1, {8'd9, 8'd7, 8'd0, 8'd5}, 0, 32'd21);
        run("defer", 1'b0, {8'd8, 8'd17, 8'd250, 8'd3}, ROWLEN + 3, 32'd278);

        // asynchronous reset in the middle of row 1
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        chain_in = 8'd99;
        repeat (6) @(negedge clk);
        check("midrun_busy", 32'(busy), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_ctrl", 32'(ctrl_obs), 32'h0);
        check("async_rst_row", 32'(row_sel), 32'h0);
        check("async_rst_result", 32'(result), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        last_result = '0;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_idle", 32'(ctrl_obs), 32'h0);
        end

        run("recover", 1'b0, {8'd1, 8'd1, 8'd1, 8'd1}, 0, 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
